// File: rtl/div_share_arb_pkg.sv
// div_arb_pkg -- shared definitions for the divider-sharing arbiter.
//
// Contents:
//   arb_state_e  one-hot arbiter FSM state (S_IDLE, S_RUN, S_RSP)
//   SAT_Q_32     saturation pattern {1'b0, all ones}; a D_W-bit design takes
//                the top D_W bits, giving {1'b0,{D_W-1{1'b1}}}
//   DIV_LAT()    grant-to-response latency in cycles for a given D_W
//   div_frac_w() fractional bits of the fixed-point quotient
//
// Optional feature macro used by this slice: DIV_ARB_ZERO_CHK_EN.
package div_arb_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_RUN  = 3'b010,
        S_RSP  = 3'b100
    } arb_state_e;

    localparam int          MAX_D_W  = 32;
    localparam logic [31:0] SAT_Q_32 = 32'h7FFF_FFFF;

    // Grant at cycle T, response valid at cycle T + DIV_LAT(D_W).
    function automatic int DIV_LAT(input int d_w);
        return d_w + 16;
    endfunction

    // Quotient is unsigned fixed point with 4 integer bits below the
    // always-zero sign bit, e.g. Q4.11 for D_W = 16.
    function automatic int div_frac_w(input int d_w);
        return d_w - 5;
    endfunction

endpackage

// File: rtl/div_share_arb_if.sv
// div_share_arb_if -- request/grant/response bundle between the requesters
// and the shared divider arbiter.
//
// Signals (names follow the block's port naming):
//   I_REQ       [N_REQ]        per-lane divide request
//   I_DIVIDEND  [N_REQ*D_W]    lane i operand at [i*D_W +: D_W]
//   I_DIVISOR   [N_REQ*D_W]    same packing
//   O_GNT       [N_REQ]        one-hot grant pulse
//   O_RSP_VLD                  result pulse
//   O_RSP_ID    [clog2(N_REQ)] owner of the result
//   O_QUOTIENT  [D_W]          result, MSB always 0
//   O_BUSY                     arbiter is not idle
//
// Handshake: I_REQ[i] acts as a level valid and must stay high with stable
// operands until O_GNT[i] pulses; the transfer happens in the cycle where
// both are high. O_GNT is the ready and is asserted for exactly one cycle.
// O_RSP_VLD is a single-cycle valid with no backpressure. Lowering I_REQ
// before the grant withdraws the request.
//
// Modports: slave = arbiter side, master = requester side.
interface div_share_arb_if #(
    parameter int N_REQ = 4,
    parameter int D_W   = 16
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]     I_REQ;
    logic [N_REQ*D_W-1:0] I_DIVIDEND;
    logic [N_REQ*D_W-1:0] I_DIVISOR;
    logic [N_REQ-1:0]     O_GNT;
    logic                 O_RSP_VLD;
    logic [ID_W-1:0]      O_RSP_ID;
    logic [D_W-1:0]       O_QUOTIENT;
    logic                 O_BUSY;

    modport slave (
        input  I_REQ, I_DIVIDEND, I_DIVISOR,
        output O_GNT, O_RSP_VLD, O_RSP_ID, O_QUOTIENT, O_BUSY
    );

    modport master (
        output I_REQ, I_DIVIDEND, I_DIVISOR,
        input  O_GNT, O_RSP_VLD, O_RSP_ID, O_QUOTIENT, O_BUSY
    );

endinterface

// File: rtl/div_share_arb_divider_pos.sv
// divider_pos -- sequential positive fixed-point divider.
//
// Computes floor((dividend << FRAC_W) / divisor) on the magnitude bits
// [D_W-2:0] of both operands (sign bits ignored), saturating to
// {1'b0,{D_W-1{1'b1}}} on overflow or zero divisor. With USE_IN_SOFTMAX
// set the result is additionally clamped to 1.0.
//
// Ports:
//   I_CLK, I_RST_N  clock, asynchronous active-low reset
//   I_START         level; a new division is taken when idle
//   I_DIVIDEND      operand, must be stable while I_START is high
//   I_DIVISOR       operand, same rule
//   O_VLD           one-cycle pulse, O_QUOTIENT valid
//   O_QUOTIENT      result, held until the next result
//
// Timing: I_START seen at cycle S gives O_VLD at cycle S + DIV_LAT(D_W) - 2.
module divider_pos
    import div_arb_pkg::*;
#(
    parameter int D_W            = 16,
    parameter int USE_IN_SOFTMAX = 0
) (
    input  logic           I_CLK,
    input  logic           I_RST_N,
    input  logic           I_START,
    input  logic [D_W-1:0] I_DIVIDEND,
    input  logic [D_W-1:0] I_DIVISOR,
    output logic           O_VLD,
    output logic [D_W-1:0] O_QUOTIENT
);

    localparam int FRAC_W  = div_frac_w(D_W);
    localparam int SH_W    = D_W - 1 - FRAC_W;
    // Busy cycles from load to result; iterations finish well before.
    localparam int RUN_CYC = DIV_LAT(D_W) - 3;
    localparam int CNT_W   = $clog2(RUN_CYC);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RUN_CYC - 1);
    localparam logic [D_W-1:0]   SAT_Q    = SAT_Q_32[MAX_D_W-1 -: D_W];
    localparam logic [D_W-1:0]   ONE_Q    = {{(D_W-1){1'b0}}, 1'b1} << FRAC_W;

    logic [D_W-2:0] a_sig;
    logic [D_W-2:0] b_sig;
    logic           sat_in;
    logic           unused_sign;

    logic             busy_q;
    logic             vld_q;
    logic             sat_q;
    logic [CNT_W-1:0] cnt_q;
    logic [D_W-2:0]   rem_q;
    logic [D_W-2:0]   low_q;
    logic [D_W-2:0]   dvs_q;
    logic [D_W-2:0]   quo_q;
    logic [D_W-1:0]   out_q;

    logic [D_W-1:0] rem_sh;
    logic           q_bit;
    logic [D_W-2:0] rem_nxt;
    logic [D_W-1:0] result;

    assign a_sig       = I_DIVIDEND[D_W-2:0];
    assign b_sig       = I_DIVISOR[D_W-2:0];
    assign unused_sign = I_DIVIDEND[D_W-1] ^ I_DIVISOR[D_W-1];

    // The quotient reaches 2^(D_W-1) exactly when a >= b << SH_W. Checking
    // that up front means only the low D_W-1 quotient bits need iterating,
    // and the starting remainder (a >> SH_W) is already below the divisor.
    // A zero divisor always lands here.
    assign sat_in = {{SH_W{1'b0}}, a_sig} >= {b_sig, {SH_W{1'b0}}};

    // One restoring-division step per cycle.
    always_comb begin
        rem_sh  = {rem_q, low_q[D_W-2]};
        q_bit   = rem_sh >= {1'b0, dvs_q};
        rem_nxt = q_bit ? (D_W-1)'(rem_sh - {1'b0, dvs_q}) : (D_W-1)'(rem_sh);
    end

    always_comb begin
        result = sat_q ? SAT_Q : {1'b0, quo_q};
        if (USE_IN_SOFTMAX != 0 && result > ONE_Q) begin
            result = ONE_Q;
        end
    end

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            busy_q <= 1'b0;
            vld_q  <= 1'b0;
            sat_q  <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            low_q  <= '0;
            dvs_q  <= '0;
            quo_q  <= '0;
            out_q  <= '0;
        end else begin
            vld_q <= 1'b0;
            if (!busy_q) begin
                // The owner drops I_START on the O_VLD edge, so a start still
                // high during O_VLD belongs to the finished division.
                if (I_START && !vld_q) begin
                    busy_q <= 1'b1;
                    cnt_q  <= '0;
                    rem_q  <= {{SH_W{1'b0}}, a_sig[D_W-2:SH_W]};
                    low_q  <= {a_sig[SH_W-1:0], {FRAC_W{1'b0}}};
                    dvs_q  <= b_sig;
                    quo_q  <= '0;
                    sat_q  <= sat_in;
                end
            end else begin
                cnt_q <= cnt_q + 1'b1;
                if (int'(cnt_q) < D_W - 1) begin
                    rem_q <= rem_nxt;
                    low_q <= {low_q[D_W-3:0], 1'b0};
                    quo_q <= {quo_q[D_W-3:0], q_bit};
                end
                if (cnt_q == LAST_CNT) begin
                    busy_q <= 1'b0;
                    vld_q  <= 1'b1;
                    out_q  <= result;
                end
            end
        end
    end

    assign O_VLD      = vld_q;
    assign O_QUOTIENT = out_q;

endmodule

// File: rtl/div_share_arb.sv
// div_share_arb -- round-robin arbiter sharing one divider_pos among N_REQ
// requesters.
//
// Ports:
//   I_CLK     clock, all state on the rising edge
//   I_RST_N   asynchronous active-low reset, also clears the divider
//   bus       div_share_arb_if.slave: I_REQ, I_DIVIDEND, I_DIVISOR in;
//             O_GNT, O_RSP_VLD, O_RSP_ID, O_QUOTIENT, O_BUSY out
//   O_STATE   current FSM state (debug)
//
// Flow: in S_IDLE one requesting lane is granted (O_GNT pulse, operands
// latched), S_RUN holds divider start until its O_VLD, S_RSP presents the
// result for one cycle. Grant to response is DIV_LAT(D_W) cycles.
// Requests seen outside S_IDLE wait for the next idle cycle.
//
// Optional feature: define DIV_ARB_ZERO_CHK_EN to answer a zero divisor
// (magnitude bits) with the saturated quotient one cycle after the grant,
// without using the divider.
module div_share_arb
    import div_arb_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int D_W            = 16,
    parameter int USE_IN_SOFTMAX = 0
) (
    input  logic             I_CLK,
    input  logic             I_RST_N,
    div_share_arb_if.slave   bus,
    output arb_state_e       O_STATE
);

    localparam int             ID_W  = $clog2(N_REQ);
    localparam logic [D_W-1:0] SAT_Q = SAT_Q_32[MAX_D_W-1 -: D_W];

    arb_state_e state_q;
    arb_state_e state_d;

    logic [ID_W-1:0] rr_ptr_q;
    logic [ID_W-1:0] id_q;
    logic [D_W-1:0]  dividend_q;
    logic [D_W-1:0]  divisor_q;
    logic [D_W-1:0]  quo_q;

    logic             gnt_any;
    logic [ID_W-1:0]  gnt_idx;
    logic [N_REQ-1:0] gnt_vec;
    logic [ID_W-1:0]  next_ptr;
    logic [D_W-1:0]   sel_dividend;
    logic [D_W-1:0]   sel_divisor;
    logic             zero_byp;

    logic           div_start;
    logic           div_vld;
    logic [D_W-1:0] div_quo;
    logic           rsp_vld;

    // Lane reached k steps after ptr, wrapping at N_REQ.
    function automatic int rot_idx(input int ptr, input int k);
        int s;
        s = ptr + k;
        return (s >= N_REQ) ? s - N_REQ : s;
    endfunction

    // Round-robin pick starting at rr_ptr. Grants exist only in S_IDLE and
    // never while reset is asserted, so O_GNT is 0 during reset even with
    // requests pending.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        gnt_vec = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!gnt_any && bus.I_REQ[rot_idx(int'(rr_ptr_q), k)]) begin
                gnt_any = 1'b1;
                gnt_idx = ID_W'(rot_idx(int'(rr_ptr_q), k));
            end
        end
        if (state_q != S_IDLE || !I_RST_N) begin
            gnt_any = 1'b0;
        end
        if (gnt_any) begin
            gnt_vec[gnt_idx] = 1'b1;
        end
    end

    assign next_ptr     = ID_W'(rot_idx(int'(gnt_idx), 1));
    assign sel_dividend = bus.I_DIVIDEND[gnt_idx*D_W +: D_W];
    assign sel_divisor  = bus.I_DIVISOR[gnt_idx*D_W +: D_W];

`ifdef DIV_ARB_ZERO_CHK_EN
    assign zero_byp = (sel_divisor[D_W-2:0] == '0);
`else
    assign zero_byp = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (gnt_any) begin
                    state_d = zero_byp ? S_RSP : S_RUN;
                end
            end
            S_RUN: begin
                if (div_vld) begin
                    state_d = S_RSP;
                end
            end
            S_RSP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            rr_ptr_q   <= '0;
            id_q       <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            quo_q      <= '0;
        end else begin
            if (gnt_any) begin
                rr_ptr_q   <= next_ptr;
                id_q       <= gnt_idx;
                dividend_q <= sel_dividend;
                divisor_q  <= sel_divisor;
                if (zero_byp) begin
                    quo_q <= SAT_Q;
                end
            end else if (state_q == S_RUN && div_vld) begin
                quo_q <= div_quo;
            end
        end
    end

    // Start is high for the whole of S_RUN: from the cycle after the grant
    // until the edge that sees the divider's O_VLD.
    assign div_start = (state_q == S_RUN);

    divider_pos #(
        .D_W            (D_W),
        .USE_IN_SOFTMAX (USE_IN_SOFTMAX)
    ) u_divider_pos (
        .I_CLK      (I_CLK),
        .I_RST_N    (I_RST_N),
        .I_START    (div_start),
        .I_DIVIDEND (dividend_q),
        .I_DIVISOR  (divisor_q),
        .O_VLD      (div_vld),
        .O_QUOTIENT (div_quo)
    );

    assign rsp_vld        = (state_q == S_RSP);
    assign bus.O_GNT      = gnt_vec;
    assign bus.O_RSP_VLD  = rsp_vld;
    // ID and quotient read as zero outside the response cycle.
    assign bus.O_RSP_ID   = rsp_vld ? id_q  : '0;
    assign bus.O_QUOTIENT = rsp_vld ? quo_q : '0;
    assign bus.O_BUSY     = (state_q != S_IDLE);
    assign O_STATE        = state_q;

endmodule

// File: tb/tb_div_share_arb.sv
// tb_div_share_arb -- bench for div_share_arb (N_REQ=4, D_W=16).
// Driver tasks raise/hold/withdraw requests; a negedge monitor keeps a
// reference model of the arbiter (round-robin pointer, busy window) and a
// scoreboard queue of expected responses {due cycle, id, quotient}.
module tb_div_share_arb;
    import div_arb_pkg::*;

    localparam int NR  = 4;
    localparam int DW  = 16;
    localparam int LAT = DW + 16;
    localparam int EW  = 52;

    logic       clk = 1'b0;
    logic       rst_n;
    arb_state_e dbg_state;
    int         cyc = 0;

    int n_chk  = 0;
    int n_fail = 0;

    logic [EW-1:0] exp_q[$];
    int            m_ptr        = 0;
    int            m_busy_until = -1;

    div_share_arb_if #(.N_REQ(NR), .D_W(DW)) bus ();

    div_share_arb #(.N_REQ(NR), .D_W(DW), .USE_IN_SOFTMAX(0)) dut (
        .I_CLK   (clk),
        .I_RST_N (rst_n),
        .bus     (bus.slave),
        .O_STATE (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: sim time expired, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Q4.11 quotient of magnitudes, saturating at 0x7FFF; zero divisor saturates.
    function automatic logic [15:0] ref_quot(input logic [15:0] a, input logic [15:0] b);
        longint unsigned na, nb, q;
        na = longint'(a & 16'h7FFF);
        nb = longint'(b & 16'h7FFF);
        if (nb == 0) return 16'h7FFF;
        q = (na * 2048) / nb;
        if (q > 64'h7FFF) return 16'h7FFF;
        return 16'(q);
    endfunction

    function automatic int ref_lat(input logic [15:0] b);
`ifdef DIV_ARB_ZERO_CHK_EN
        return ((b & 16'h7FFF) == 0) ? 1 : LAT;
`else
        return LAT;
`endif
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [NR-1:0] e_gnt;
        logic          e_vld;
        logic          e_busy;
        logic [EW-1:0] head;
        logic [15:0]   a, b;
        arb_state_e    e_st;
        bit            found;
        int            g;
        if (!rst_n) begin
            chk(bus.O_GNT == 0, "rst_gnt", bus.O_GNT, 0);
            chk(bus.O_RSP_VLD == 0, "rst_rsp_vld", bus.O_RSP_VLD, 0);
            chk(bus.O_RSP_ID == 0, "rst_rsp_id", bus.O_RSP_ID, 0);
            chk(bus.O_QUOTIENT == 0, "rst_quot", bus.O_QUOTIENT, 0);
            chk(bus.O_BUSY == 0, "rst_busy", bus.O_BUSY, 0);
            chk(dbg_state == S_IDLE, "rst_state", dbg_state, S_IDLE);
            exp_q.delete();
            m_ptr        = 0;
            m_busy_until = -1;
        end else begin
            e_gnt = '0;
            found = 0;
            g     = 0;
            if (cyc > m_busy_until) begin
                for (int k = 0; k < NR; k++) begin
                    if (!found && bus.I_REQ[(m_ptr + k) % NR]) begin
                        found = 1;
                        g     = (m_ptr + k) % NR;
                    end
                end
            end
            if (found) e_gnt[g] = 1'b1;
            e_busy = (cyc <= m_busy_until);
            e_vld  = (exp_q.size() > 0) && (int'(exp_q[0][51:20]) == cyc);
            e_st   = e_vld ? S_RSP : (e_busy ? S_RUN : S_IDLE);

            chk(bus.O_GNT == e_gnt, "gnt", bus.O_GNT, e_gnt);
            chk(bus.O_BUSY == e_busy, "busy", bus.O_BUSY, e_busy);
            chk(bus.O_RSP_VLD == e_vld, "rsp_vld", bus.O_RSP_VLD, e_vld);
            chk(dbg_state == e_st, "state", dbg_state, e_st);
            chk(!(bus.O_GNT != 0 && bus.O_RSP_VLD), "gnt_rsp_overlap", {bus.O_GNT, bus.O_RSP_VLD}, 0);

            if (e_vld) begin
                head = exp_q.pop_front();
                if (bus.O_RSP_VLD) begin
                    chk(bus.O_RSP_ID == head[17:16], "rsp_id", bus.O_RSP_ID, head[19:16]);
                    chk(bus.O_QUOTIENT == head[15:0], "quotient", bus.O_QUOTIENT, head[15:0]);
                end
            end

            if (found) begin
                a = bus.I_DIVIDEND[g*DW +: DW];
                b = bus.I_DIVISOR[g*DW +: DW];
                exp_q.push_back({32'(cyc + ref_lat(b)), 4'(g), ref_quot(a, b)});
                m_ptr        = (g + 1) % NR;
                m_busy_until = cyc + ref_lat(b);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // One cycle: note grants seen mid-cycle, then drop those requests.
    task automatic tick();
        logic [NR-1:0] g;
        @(negedge clk);
        g = bus.O_GNT;
        @(posedge clk);
        #1;
        bus.I_REQ = bus.I_REQ & ~g;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic request(input int lane, input logic [15:0] a, input logic [15:0] b);
        bus.I_DIVIDEND[lane*DW +: DW] = a;
        bus.I_DIVISOR[lane*DW +: DW]  = b;
        bus.I_REQ[lane]               = 1'b1;
    endtask

    function automatic logic [15:0] rand_div();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel == 0) return 16'h0000;
        if (sel <= 3) return 16'($urandom_range(1, 16));
        return 16'($urandom_range(0, 16'hFFFF));
    endfunction

    task automatic wait_drain(input int max_cyc);
        int n;
        n = 0;
        while ((bus.I_REQ != 0 || exp_q.size() != 0 || bus.O_BUSY) && n < max_cyc) begin
            tick();
            n++;
        end
        chk(n < max_cyc, "drain_timeout", n, max_cyc);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n          = 1'b0;
        bus.I_REQ      = '0;
        bus.I_DIVIDEND = '0;
        bus.I_DIVISOR  = '0;
        bus.I_REQ[1]   = 1'b1;   // pending request must not be granted in reset
        repeat (3) @(posedge clk);
        #1;
        bus.I_REQ = '0;
        rst_n     = 1'b1;
        tick();

        // Single lane: 0x0100 / 0x0040 -> 0x2000 after 32 cycles.
        request(0, 16'h0100, 16'h0040);
        wait_drain(100);

        // All lanes together from the reset pointer: order 0,1,2,3.
        for (int l = 0; l < NR; l++) request(l, 16'($urandom), rand_div());
        wait_drain(300);

        // Lane 2 arrives during lane 0's division.
        request(0, 16'h1234, 16'h0031);
        tick_n(5);
        request(2, 16'h7FFF, 16'h0100);
        wait_drain(200);

        // Zero divisor, and divisor with only the ignored sign bit set.
        request(1, 16'h1234, 16'h0000);
        wait_drain(100);
        request(1, 16'h7FFF, 16'h8000);
        wait_drain(100);

        // Saturation boundary and sign bits on both operands.
        request(3, 16'h0400, 16'h0040);
        wait_drain(100);
        request(3, 16'h83FF, 16'h8040);
        wait_drain(100);

        // Request withdrawn while busy: never granted.
        request(0, 16'h0555, 16'h0003);
        tick_n(3);
        request(1, 16'h0222, 16'h0011);
        tick_n(4);
        bus.I_REQ[1] = 1'b0;
        wait_drain(100);

        // Reset ten cycles into a division, then a fresh round.
        request(3, 16'h4321, 16'h0007);
        tick_n(10);
        rst_n = 1'b0;
        #1;
        chk(bus.O_BUSY == 0 && bus.O_GNT == 0 && bus.O_RSP_VLD == 0,
            "rst_async_outputs", {bus.O_BUSY, bus.O_GNT, bus.O_RSP_VLD}, 0);
        tick_n(2);
        rst_n = 1'b1;
        request(2, 16'h0100, 16'h0040);
        request(1, 16'h0FFF, 16'h0123);
        wait_drain(200);

        // Random traffic with occasional withdrawals.
        repeat (600) begin
            for (int l = 0; l < NR; l++) begin
                if (!bus.I_REQ[l] && $urandom_range(0, 5) == 0) begin
                    request(l, 16'($urandom), rand_div());
                end else if (bus.I_REQ[l] && $urandom_range(0, 39) == 0) begin
                    bus.I_REQ[l] = 1'b0;
                end
            end
            tick();
        end
        wait_drain(600);

        chk(exp_q.size() == 0, "scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/div_share_arb.md
DIV_SHARE_ARB -- requirements
Module: div_share_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters sharing one divider, range 2..16.
REQ-002 SHALL have parameter D_W, default 16: operand and quotient width, forwarded to the divider.
REQ-003 SHALL have parameter USE_IN_SOFTMAX, default 0: forwarded unchanged to the divider.
REQ-004 I_CLK  input  1  single clock; all state on rising edge.
REQ-005 I_RST_N  input  1  asynchronous, active-low reset.
REQ-006 I_REQ  input  N_REQ  per-requester divide request, level-held until granted.
REQ-007 I_DIVIDEND  input  N_REQ*D_W  packed dividends; lane i at [i*D_W +: D_W].
REQ-008 I_DIVISOR  input  N_REQ*D_W  packed divisors, same packing.
REQ-009 O_GNT  output  N_REQ  one-hot, one-cycle pulse; operands of that lane captured this cycle.
REQ-010 O_RSP_VLD  output  1  one-cycle pulse; result valid.
REQ-011 O_RSP_ID  output  $clog2(N_REQ)  index of the requester owning the result.
REQ-012 O_QUOTIENT  output  D_W  quotient, MSB always 0.
REQ-013 O_BUSY  output  1  high whenever FSM is not S_IDLE.

Function
REQ-014 FSM states: S_IDLE, S_RUN, S_RSP; one-hot encoded.
REQ-015 S_IDLE with any I_REQ bit set: grant exactly one lane by round-robin, pulse O_GNT, latch operands and ID, go S_RUN.
REQ-016 Round-robin: search starts at pointer rr_ptr; after a grant to lane g, rr_ptr <= (g+1) mod N_REQ; rr_ptr resets to 0.
REQ-017 S_RUN: divider start held high from the cycle after grant, with latched operands stable, until divider O_VLD is seen.
REQ-018 On divider O_VLD: capture quotient, drop start on the same edge, go S_RSP.
REQ-019 S_RSP: O_RSP_VLD=1 for one cycle with O_QUOTIENT and O_RSP_ID; go S_IDLE.
REQ-020 Grant-to-response latency SHALL be D_W+16 cycles (32 for D_W=16); next grant no earlier than the following cycle.
REQ-021 Requests arriving while O_BUSY are ignored; the requester holds I_REQ, and the request is served on a later S_IDLE.
REQ-022 A requester deasserting I_REQ before grant SHALL lose its request with no side effect.
REQ-023 O_GNT and O_RSP_VLD SHALL never be high in the same cycle.
REQ-024 Only operand bits [D_W-2:0] are significant; the sign bit is ignored, as in the divider.

Reset
REQ-025 Reset asserted mid-operation SHALL abort the division and clear the divider through the shared reset.
REQ-026 During and after reset, all outputs are 0, FSM is S_IDLE, rr_ptr is 0, and divider start is 0.

Configuration
REQ-027 Macro DIV_ARB_ZERO_CHK_EN defined: a latched divisor with bits [D_W-2:0] all zero bypasses the divider.
REQ-028 In that bypass, the FSM goes S_IDLE->S_RSP with O_QUOTIENT={1'b0,{D_W-1{1'b1}}}, response at grant+1.
REQ-029 Macro DIV_ARB_ZERO_CHK_EN undefined: zero divisors run through the divider unchanged, with normal latency.

Structure
REQ-030 Shared package div_arb_pkg SHALL hold the state enum, the saturation constant, and the latency constant DIV_LAT(D_W)=D_W+16.
REQ-031 Exactly one sub-module, divider_pos, instantiated once, with D_W and USE_IN_SOFTMAX passed through.

Verification
REQ-032 Single lane: I_REQ=0001, dividend=0x0100, divisor=0x0040, D_W=16 -> O_GNT=0001 at T; O_RSP_VLD at T+32, ID=0, quotient=0x2000.
REQ-033 All four lanes request together from reset -> grants in order 0,1,2,3; each response ID matches its grant.
REQ-034 Lane 2 requests during lane 0's division -> lane 2 is granted the cycle after lane 0's O_RSP_VLD; O_GNT and O_RSP_VLD never overlap.
REQ-035 Divisor=0 on lane 1, macro defined -> O_RSP_VLD at T+1 with quotient 0x7FFF; macro undefined -> response at T+32.
REQ-036 I_RST_N pulsed low at T+10 of a division -> all outputs 0 immediately; a new request after release gets a correct result.
